// File: rtl/vram_arbiter.sv
// Arbitrates the single SDRAM command port between VDP slot strobes, refresh and an
// auxiliary requester, with fixed command spacing and read-tag steering of returned data.
module vram_arbiter #(
  parameter int ADDR_W      = 23,
  parameter int CMD_SPACING = 8,
  parameter int RD_LATENCY  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enabled,
  input  logic              vdp_read,
  input  logic              vdp_write,
  input  logic              vdp_refresh,
  input  logic [ADDR_W-1:0] vdp_addr,
  input  logic [7:0]        vdp_din8,
  output logic [15:0]       vdp_dout16,
  input  logic              aux_req,
  input  logic              aux_wr,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_din8,
  output logic              aux_ack,
  output logic [15:0]       aux_dout16,
  output logic              aux_dout_valid,
  output logic              overrun,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din8,
  input  logic [15:0]       mem_dout16
);
  typedef enum logic [0:0] {S_IDLE, S_SPACE} state_t;
  localparam logic [3:0] SPACE_LOAD = 4'(CMD_SPACING - 2);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_lvl_q, wr_lvl_q, ref_lvl_q;
  logic              vdp_pend_q, vdp_is_wr_q, ref_pend_q;
  logic [ADDR_W-1:0] vdp_addr_q;
  logic [7:0]        vdp_din_q;
  logic              overrun_q;
  logic              mem_read_q, mem_write_q, mem_refresh_q, aux_ack_q, cmd_aux_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_aux_q;
  logic [15:0]       vdp_dout_q, aux_dout_q;
  logic              aux_vld_q;

  logic rd_edge, wr_edge, ref_edge, vdp_edge;
  logic idle_en, grant_vdp, grant_ref, grant_aux, grant_any;

  assign rd_edge  = vdp_read & ~rd_lvl_q;
  assign wr_edge  = vdp_write & ~wr_lvl_q;
  assign ref_edge = vdp_refresh & ~ref_lvl_q;
  assign vdp_edge = rd_edge | wr_edge;

  // Aux also yields to a VDP/refresh edge arriving this cycle, so it never steals a slot.
  assign idle_en   = (state_q == S_IDLE) && mem_enabled;
  assign grant_vdp = idle_en && vdp_pend_q;
  assign grant_ref = idle_en && !vdp_pend_q && ref_pend_q;
  assign grant_aux = idle_en && !vdp_pend_q && !ref_pend_q && !vdp_edge && !ref_edge && aux_req;
  assign grant_any = grant_vdp | grant_ref | grant_aux;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = S_SPACE;
          cnt_d   = SPACE_LOAD;
        end
      end
      S_SPACE: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_lvl_q      <= 1'b0;
      wr_lvl_q      <= 1'b0;
      ref_lvl_q     <= 1'b0;
      vdp_pend_q    <= 1'b0;
      vdp_is_wr_q   <= 1'b0;
      ref_pend_q    <= 1'b0;
      vdp_addr_q    <= '0;
      vdp_din_q     <= 8'd0;
      overrun_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      aux_ack_q     <= 1'b0;
      cmd_aux_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= 8'd0;
    end else begin
      rd_lvl_q  <= vdp_read;
      wr_lvl_q  <= vdp_write;
      ref_lvl_q <= vdp_refresh;

      // Clear on grant first so an edge in the same cycle re-arms the flag.
      if (grant_vdp) vdp_pend_q <= 1'b0;
      if (vdp_edge) begin
        vdp_pend_q  <= 1'b1;
        vdp_is_wr_q <= wr_edge;
        vdp_addr_q  <= vdp_addr;
        vdp_din_q   <= vdp_din8;
      end
      if (grant_ref) ref_pend_q <= 1'b0;
      if (ref_edge) ref_pend_q <= 1'b1;
      if ((vdp_edge && vdp_pend_q && !grant_vdp) || (ref_edge && ref_pend_q && !grant_ref))
        overrun_q <= 1'b1;

      mem_read_q    <= (grant_vdp && !vdp_is_wr_q) || (grant_aux && !aux_wr);
      mem_write_q   <= (grant_vdp && vdp_is_wr_q) || (grant_aux && aux_wr);
      mem_refresh_q <= grant_ref;
      aux_ack_q     <= grant_aux;
      cmd_aux_q     <= grant_aux;
      if (grant_vdp) begin
        mem_addr_q <= vdp_addr_q;
        mem_din_q  <= vdp_din_q;
      end else if (grant_ref) begin
        mem_addr_q <= '0;
        mem_din_q  <= 8'd0;
      end else if (grant_aux) begin
        mem_addr_q <= aux_addr;
        mem_din_q  <= aux_din8;
      end
    end
  end

  // Tag pipeline starts from the issued pulse; its last stage lines up with valid read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_q  <= '0;
      tag_aux_q  <= '0;
      vdp_dout_q <= 16'd0;
      aux_dout_q <= 16'd0;
      aux_vld_q  <= 1'b0;
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        if (i == 0) begin
          tag_vld_q[i] <= mem_read_q;
          tag_aux_q[i] <= cmd_aux_q;
        end else begin
          tag_vld_q[i] <= tag_vld_q[i-1];
          tag_aux_q[i] <= tag_aux_q[i-1];
        end
      end
      aux_vld_q <= tag_vld_q[RD_LATENCY-1] && tag_aux_q[RD_LATENCY-1];
      if (tag_vld_q[RD_LATENCY-1]) begin
        if (tag_aux_q[RD_LATENCY-1]) aux_dout_q <= mem_dout16;
        else vdp_dout_q <= mem_dout16;
      end
    end
  end

  assign vdp_dout16     = vdp_dout_q;
  assign aux_ack        = aux_ack_q;
  assign aux_dout16     = aux_dout_q;
  assign aux_dout_valid = aux_vld_q;
  assign overrun        = overrun_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_refresh    = mem_refresh_q;
  assign mem_addr       = mem_addr_q;
  assign mem_din8       = mem_din_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a small controller model returns read data after a
// fixed latency and a monitor logs command pulses by cycle number.
module tb_vram_arbiter;
  localparam int ADDR_W = 23;
  localparam int RD_LAT = 5;

  logic              clk = 1'b0;
  logic              reset, mem_enabled;
  logic              vdp_read, vdp_write, vdp_refresh;
  logic [ADDR_W-1:0] vdp_addr, aux_addr, mem_addr;
  logic [7:0]        vdp_din8, aux_din8, mem_din8;
  logic [15:0]       vdp_dout16, aux_dout16, mem_dout16;
  logic              aux_req, aux_wr, aux_ack, aux_dout_valid, overrun;
  logic              mem_read, mem_write, mem_refresh;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rd = 0, n_wr = 0, n_ref = 0, n_ack = 0, n_av = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0, last_ref_cyc = 0, last_ack_cyc = 0;
  logic [ADDR_W-1:0] last_rd_addr;
  logic [15:0]       rd_word = 16'h0000;
  logic [RD_LAT:0]   rd_sh = '0;

  vram_arbiter #(.ADDR_W(ADDR_W), .CMD_SPACING(8), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .reset(reset), .mem_enabled(mem_enabled),
    .vdp_read(vdp_read), .vdp_write(vdp_write), .vdp_refresh(vdp_refresh),
    .vdp_addr(vdp_addr), .vdp_din8(vdp_din8), .vdp_dout16(vdp_dout16),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_din8(aux_din8),
    .aux_ack(aux_ack), .aux_dout16(aux_dout16), .aux_dout_valid(aux_dout_valid),
    .overrun(overrun), .mem_read(mem_read), .mem_write(mem_write),
    .mem_refresh(mem_refresh), .mem_addr(mem_addr), .mem_din8(mem_din8),
    .mem_dout16(mem_dout16)
  );

  always #5 clk = ~clk;

  // Controller model and pulse monitor; data is valid only in the exact latency cycle.
  initial begin
    mem_dout16 = 16'h0BAD;
    forever begin
      @(posedge clk); #1;
      cyc++;
      rd_sh = {rd_sh[RD_LAT-1:0], mem_read};
      mem_dout16 = rd_sh[RD_LAT] ? rd_word : 16'h0BAD;
      if (mem_read)       begin n_rd++; last_rd_cyc = cyc; last_rd_addr = mem_addr; end
      if (mem_write)      begin n_wr++; last_wr_cyc = cyc; end
      if (mem_refresh)    begin n_ref++; last_ref_cyc = cyc; end
      if (aux_ack)        begin n_ack++; last_ack_cyc = cyc; end
      if (aux_dout_valid) n_av++;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_enabled = 1'b0;
    vdp_read = 0; vdp_write = 0; vdp_refresh = 0; vdp_addr = '0; vdp_din8 = '0;
    aux_req = 0; aux_wr = 0; aux_addr = '0; aux_din8 = '0;
    repeat (3) step();
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b exp 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b exp 0", mem_write); end
    checks++; if (mem_refresh !== 1'b0) begin errors++; $display("FAIL reset_mem_refresh: got %b exp 0", mem_refresh); end
    checks++; if (mem_addr !== 23'h0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
    checks++; if (mem_din8 !== 8'h0) begin errors++; $display("FAIL reset_mem_din8: got %h exp 0", mem_din8); end
    checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL reset_aux_ack: got %b exp 0", aux_ack); end
    checks++; if (aux_dout_valid !== 1'b0) begin errors++; $display("FAIL reset_aux_valid: got %b exp 0", aux_dout_valid); end
    checks++; if (vdp_dout16 !== 16'h0) begin errors++; $display("FAIL reset_vdp_dout: got %h exp 0", vdp_dout16); end
    checks++; if (aux_dout16 !== 16'h0) begin errors++; $display("FAIL reset_aux_dout: got %h exp 0", aux_dout16); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_vdp_read();
    int c0, r, n0;
    mem_enabled = 1'b1;
    repeat (10) step();
    rd_word = 16'hBEEF; n0 = n_rd; c0 = cyc;
    vdp_read = 1'b1; vdp_addr = 23'h00123;
    repeat (4) step();
    vdp_read = 1'b0;
    checks++; if (n_rd - n0 !== 1) begin errors++; $display("FAIL vdp_rd_count: got %0d exp 1", n_rd - n0); end
    checks++; if (last_rd_cyc !== c0 + 2) begin errors++; $display("FAIL vdp_rd_cycle: got %0d exp %0d", last_rd_cyc, c0 + 2); end
    checks++; if (last_rd_addr !== 23'h00123) begin errors++; $display("FAIL vdp_rd_addr: got %h exp 00123", last_rd_addr); end
    r = c0 + 2;
    while (cyc < r + RD_LAT) step();
    checks++; if (vdp_dout16 !== 16'h0000) begin errors++; $display("FAIL vdp_dout_early: got %h exp 0000", vdp_dout16); end
    step();
    checks++; if (vdp_dout16 !== 16'hBEEF) begin errors++; $display("FAIL vdp_dout: got %h exp BEEF", vdp_dout16); end
    repeat (10) step();
    checks++; if (n_rd - n0 !== 1) begin errors++; $display("FAIL vdp_rd_single: got %0d exp 1", n_rd - n0); end
    checks++; if (n_av !== 0) begin errors++; $display("FAIL vdp_no_aux_valid: got %0d exp 0", n_av); end
  endtask

  task automatic test_aux_read();
    int c0, n0, a0, v0;
    repeat (4) step();
    rd_word = 16'h1234; n0 = n_rd; a0 = n_ack; v0 = n_av; c0 = cyc;
    aux_req = 1'b1; aux_wr = 1'b0; aux_addr = 23'h40000;
    step();
    checks++; if (aux_ack !== 1'b1) begin errors++; $display("FAIL aux_ack: got %b exp 1", aux_ack); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL aux_mem_read: got %b exp 1", mem_read); end
    checks++; if (mem_addr !== 23'h40000) begin errors++; $display("FAIL aux_addr: got %h exp 40000", mem_addr); end
    aux_req = 1'b0;
    step();
    checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL aux_ack_pulse: got %b exp 0", aux_ack); end
    while (cyc < c0 + 1 + RD_LAT) step();
    checks++; if (aux_dout_valid !== 1'b0) begin errors++; $display("FAIL aux_valid_early: got %b exp 0", aux_dout_valid); end
    step();
    checks++; if (aux_dout_valid !== 1'b1) begin errors++; $display("FAIL aux_valid: got %b exp 1", aux_dout_valid); end
    checks++; if (aux_dout16 !== 16'h1234) begin errors++; $display("FAIL aux_dout: got %h exp 1234", aux_dout16); end
    step();
    checks++; if (aux_dout_valid !== 1'b0) begin errors++; $display("FAIL aux_valid_pulse: got %b exp 0", aux_dout_valid); end
    repeat (10) step();
    checks++; if (n_rd - n0 !== 1) begin errors++; $display("FAIL aux_rd_count: got %0d exp 1", n_rd - n0); end
    checks++; if (n_ack - a0 !== 1) begin errors++; $display("FAIL aux_ack_count: got %0d exp 1", n_ack - a0); end
    checks++; if (n_av - v0 !== 1) begin errors++; $display("FAIL aux_valid_count: got %0d exp 1", n_av - v0); end
    checks++; if (vdp_dout16 !== 16'hBEEF) begin errors++; $display("FAIL aux_vdp_dout_held: got %h exp BEEF", vdp_dout16); end
  endtask

  task automatic test_write_vs_aux();
    int c0, a0, w0;
    a0 = n_ack; w0 = n_wr; c0 = cyc;
    vdp_write = 1'b1; vdp_addr = 23'h000AB; vdp_din8 = 8'h5C;
    aux_req = 1'b1; aux_wr = 1'b1; aux_addr = 23'h0ABCDE; aux_din8 = 8'hA5;
    step();
    checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL wva_no_early_ack: got %b exp 0", aux_ack); end
    step();
    vdp_write = 1'b0;
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wva_vdp_write: got %b exp 1", mem_write); end
    checks++; if (mem_addr !== 23'h000AB) begin errors++; $display("FAIL wva_vdp_addr: got %h exp 000AB", mem_addr); end
    checks++; if (mem_din8 !== 8'h5C) begin errors++; $display("FAIL wva_vdp_din: got %h exp 5C", mem_din8); end
    checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL wva_ack_on_vdp: got %b exp 0", aux_ack); end
    while (cyc < c0 + 10) step();
    checks++; if (aux_ack !== 1'b1) begin errors++; $display("FAIL wva_aux_ack: got %b exp 1", aux_ack); end
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wva_aux_write: got %b exp 1", mem_write); end
    checks++; if (mem_addr !== 23'h0ABCDE) begin errors++; $display("FAIL wva_aux_addr: got %h exp 0ABCDE", mem_addr); end
    checks++; if (mem_din8 !== 8'hA5) begin errors++; $display("FAIL wva_aux_din: got %h exp A5", mem_din8); end
    aux_req = 1'b0; aux_wr = 1'b0;
    repeat (10) step();
    checks++; if (n_ack - a0 !== 1) begin errors++; $display("FAIL wva_ack_count: got %0d exp 1", n_ack - a0); end
    checks++; if (n_wr - w0 !== 2) begin errors++; $display("FAIL wva_write_count: got %0d exp 2", n_wr - w0); end
  endtask

  task automatic test_ref_in_space();
    int c0, r0, f0;
    r0 = n_rd; f0 = n_ref; c0 = cyc;
    vdp_read = 1'b1; vdp_addr = 23'h00010;
    step();
    vdp_read = 1'b0;
    step();
    checks++; if (mem_read !== 1'b1 || mem_addr !== 23'h00010) begin errors++; $display("FAIL sp_first_read: got rd=%b addr=%h exp rd=1 addr=00010", mem_read, mem_addr); end
    vdp_read = 1'b1; vdp_addr = 23'h00020; vdp_refresh = 1'b1;
    step();
    vdp_read = 1'b0; vdp_refresh = 1'b0;
    while (cyc < c0 + 10) step();
    checks++; if (mem_read !== 1'b1 || mem_addr !== 23'h00020) begin errors++; $display("FAIL sp_second_read: got rd=%b addr=%h exp rd=1 addr=00020", mem_read, mem_addr); end
    while (cyc < c0 + 18) step();
    checks++; if (mem_refresh !== 1'b1 || mem_addr !== 23'h0) begin errors++; $display("FAIL sp_refresh: got ref=%b addr=%h exp ref=1 addr=0", mem_refresh, mem_addr); end
    checks++; if (n_ref - f0 !== 1) begin errors++; $display("FAIL sp_ref_count: got %0d exp 1", n_ref - f0); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sp_no_overrun: got %b exp 0", overrun); end
    vdp_read = 1'b1; vdp_addr = 23'h00030;
    step();
    vdp_read = 1'b0;
    step();
    vdp_read = 1'b1; vdp_addr = 23'h00031;
    step();
    vdp_read = 1'b0;
    step();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL sp_overrun: got %b exp 1", overrun); end
    while (cyc < c0 + 26) step();
    checks++; if (mem_read !== 1'b1 || mem_addr !== 23'h00031) begin errors++; $display("FAIL sp_overrun_read: got rd=%b addr=%h exp rd=1 addr=00031", mem_read, mem_addr); end
    repeat (10) step();
    checks++; if (n_rd - r0 !== 3) begin errors++; $display("FAIL sp_rd_count: got %0d exp 3", n_rd - r0); end
  endtask

  task automatic test_mem_disabled();
    int c1, tot0;
    mem_enabled = 1'b0;
    repeat (4) step();
    tot0 = n_rd + n_wr + n_ref + n_ack;
    vdp_write = 1'b1; vdp_addr = 23'h00055; vdp_din8 = 8'h66;
    aux_req = 1'b1; aux_wr = 1'b0; aux_addr = 23'h00077;
    step();
    vdp_write = 1'b0;
    repeat (9) step();
    checks++; if (n_rd + n_wr + n_ref + n_ack !== tot0) begin errors++; $display("FAIL dis_no_cmds: got %0d exp %0d", n_rd + n_wr + n_ref + n_ack, tot0); end
    c1 = cyc;
    mem_enabled = 1'b1;
    step();
    checks++; if (mem_write !== 1'b1 || mem_addr !== 23'h00055 || mem_din8 !== 8'h66) begin errors++; $display("FAIL dis_vdp_write: got wr=%b addr=%h din=%h exp wr=1 addr=00055 din=66", mem_write, mem_addr, mem_din8); end
    checks++; if (aux_ack !== 1'b0) begin errors++; $display("FAIL dis_ack_early: got %b exp 0", aux_ack); end
    while (cyc < c1 + 9) step();
    checks++; if (aux_ack !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 23'h00077) begin errors++; $display("FAIL dis_aux_read: got ack=%b rd=%b addr=%h exp ack=1 rd=1 addr=00077", aux_ack, mem_read, mem_addr); end
    aux_req = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset_midop();
    int v0;
    rd_word = 16'h7777;
    aux_req = 1'b1; aux_wr = 1'b0; aux_addr = 23'h00100;
    step();
    checks++; if (mem_read !== 1'b1 || aux_ack !== 1'b1) begin errors++; $display("FAIL rm_aux_issue: got rd=%b ack=%b exp 1 1", mem_read, aux_ack); end
    aux_req = 1'b0; reset = 1'b1;
    step();
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_refresh !== 1'b0 || aux_ack !== 1'b0) begin errors++; $display("FAIL rm_pulses: got rd=%b wr=%b ref=%b ack=%b exp 0", mem_read, mem_write, mem_refresh, aux_ack); end
    checks++; if (mem_addr !== 23'h0 || mem_din8 !== 8'h0) begin errors++; $display("FAIL rm_addr_din: got addr=%h din=%h exp 0", mem_addr, mem_din8); end
    checks++; if (vdp_dout16 !== 16'h0 || aux_dout16 !== 16'h0) begin errors++; $display("FAIL rm_dout: got vdp=%h aux=%h exp 0", vdp_dout16, aux_dout16); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rm_overrun: got %b exp 0", overrun); end
    reset = 1'b0;
    v0 = n_av;
    repeat (10) step();
    checks++; if (n_av !== v0) begin errors++; $display("FAIL rm_no_valid: got %0d exp %0d", n_av, v0); end
    checks++; if (aux_dout16 !== 16'h0) begin errors++; $display("FAIL rm_aux_dout_after: got %h exp 0", aux_dout16); end
  endtask

  initial begin
    test_reset();
    test_vdp_read();
    test_aux_read();
    test_write_vs_aux();
    test_ref_in_space();
    test_mem_disabled();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
